multicast_router: RTL

Parametrised, registered successor to the combinational multibroadcasting network. One input stream is delivered to a programmable destination set among N = 2^ADDR_W outputs. The destination set is an address plus a per-bit don't-care mask, so unicast, subtree multicast and full broadcast are all one encoding. Unlike the combinational version, the block holds each item in a one-entry buffer and tracks per-destination valid/ready handshakes. It sits between a single producer and an array of independently back-pressuring consumers.

---
 rtl/multicast_router.sv | 104 ++++++++++
 1 files changed

// File: rtl/multicast_router.sv
// multicast_router: a one-entry buffer that delivers each accepted item to
// every output selected by an address plus a per-bit don't-care mask.
// Each destination handshakes on its own. The item is released once the
// last selected destination has taken it.
module multicast_router #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic [ADDR_W-1:0]        in_addr_i,
    input  logic [ADDR_W-1:0]        in_mask_i,
    output logic [(2**ADDR_W)-1:0]   out_valid_o,
    input  logic [(2**ADDR_W)-1:0]   out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         done_cnt_o
);

    localparam int N = 2**ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    done_q, done_d;

    logic [N-1:0]        dest_s;
    logic [N-1:0]        remain_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                complete_s;

    // Decode the destination set: output j matches when every unmasked address bit agrees.
    always_comb begin
        dest_s = {N{1'b0}};
        for (int j = 0; j < N; j++) begin
            if (((ADDR_W'(j) ^ in_addr_i) & ~in_mask_i) == {ADDR_W{1'b0}}) begin
                dest_s[j] = 1'b1;
            end else begin
                dest_s[j] = 1'b0;
            end
        end
    end

    // Next-state logic: delivery clears, completion counting, and accept of a new item.
    always_comb begin
        remain_s   = pending_q & ~out_ready_i;
        in_ready_s = (remain_s == {N{1'b0}});
        accept_s   = in_valid_i & in_ready_s;
        complete_s = (state_q == ST_HOLD) & in_ready_s;

        if (accept_s) begin
            pending_d = dest_s;
            data_d    = in_data_i;
        end else begin
            pending_d = remain_s;
            data_d    = data_q;
        end

        if (complete_s && (done_q != {CNT_W{1'b1}})) begin
            done_d = done_q + CNT_W'(1);
        end else begin
            done_d = done_q;
        end

        if (pending_d != {N{1'b0}}) begin
            state_d = ST_HOLD;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // State registers: reset discards any held item without counting it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= {N{1'b0}};
            data_q    <= {DATA_W{1'b0}};
            done_q    <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    // in_ready stays combinational so a completing item can be replaced in the same cycle.
    assign in_ready_o  = in_ready_s;
    assign out_valid_o = pending_q;
    assign out_data_o  = data_q;
    assign busy_o      = (state_q == ST_HOLD);
    assign done_cnt_o  = done_q;

endmodule
